serial_subtractor_16: RTL

//   Multi-cycle 16-bit subtractor computing x - y, DIGIT_W bits per cycle, LSB first.

---
 rtl/serial_subtractor_16.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_subtractor_16.sv
// Multi-cycle x - y: a DIGIT_W-bit borrow slice reused over WIDTH/DIGIT_W cycles, LSB first.
// Result and flags are registered on entry to DONE and held until the next one.
//
//   state  | meaning
//   IDLE   | waiting for start, outputs hold the last result (or reset values)
//   RUN    | one digit subtracted per cycle, then one cycle to publish the result
//   DONE   | result valid; a new start is accepted here as well
module serial_subtractor_16 #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovfl,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_state_next;
  logic   w_accept, w_finish;

  logic [WIDTH-1:0]         r_x_sh, r_y_sh, r_diff_sh;
  logic [CW-1:0]            r_count;
  logic                     r_borrow;
  logic                     r_x_msb, r_y_msb;
  logic [DIGIT_W:0]         w_sub;
  logic [WIDTH+DIGIT_W-1:0] w_diff_cat;
  logic [WIDTH-1:0]         w_diff_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_accept     = 1'b1;
        end
      end
      S_RUN: begin
        // all N digits are in diff_sh once count reaches N; this cycle publishes them
        if (r_count == LAST) begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  assign w_sub = {1'b0, r_x_sh[DIGIT_W-1:0]} - {1'b0, r_y_sh[DIGIT_W-1:0]}
               - {{DIGIT_W{1'b0}}, r_borrow};
  assign w_diff_cat   = {w_sub[DIGIT_W-1:0], r_diff_sh};
  assign w_diff_shift = w_diff_cat[WIDTH+DIGIT_W-1:DIGIT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_sh    <= '0;
      r_y_sh    <= '0;
      r_diff_sh <= '0;
      r_count   <= '0;
      r_borrow  <= 1'b0;
      r_x_msb   <= 1'b0;
      r_y_msb   <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovfl      <= 1'b0;
      zero      <= 1'b0;
    end else if (w_accept) begin
      r_x_sh    <= x;
      r_y_sh    <= y;
      r_diff_sh <= '0;
      r_count   <= '0;
      r_borrow  <= 1'b0;
      r_x_msb   <= x[WIDTH-1];
      r_y_msb   <= y[WIDTH-1];
    end else if (w_finish) begin
      diff <= r_diff_sh;
      bout <= r_borrow;
      ovfl <= (r_x_msb != r_y_msb) && (r_diff_sh[WIDTH-1] != r_x_msb);
      zero <= (r_diff_sh == '0);
    end else if (busy) begin
      r_x_sh    <= r_x_sh >> DIGIT_W;
      r_y_sh    <= r_y_sh >> DIGIT_W;
      r_diff_sh <= w_diff_shift;
      r_borrow  <= w_sub[DIGIT_W];
      r_count   <= r_count + 1'b1;
    end
  end

endmodule
